// File: rtl/mac_rx_pkg.sv
// Shared definitions for the MAC rx -> ibuff writer: FSM states, header layout
// and byte-enable helpers.
package mac_rx_pkg;

    localparam int unsigned HDR_LEN_LSB = 0;
    localparam int unsigned HDR_LEN_MSB = 15;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_RCV  = 2'd2,
        ST_DROP = 2'd3
    } rx_state_e;

    function automatic logic [3:0] dv2bytes(input logic [7:0] dv);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(dv[i]);
        end
        return n;
    endfunction

    // Contiguous-low mask: dv+1 is a power of two (0x01, 0x03, ... 0xFF).
    function automatic logic dv_is_contig(input logic [7:0] dv);
        logic [8:0] p;
        p = {1'b0, dv} + 9'd1;
        return (dv != 8'd0) && ((p & (p - 9'd1)) == 9'd0);
    endfunction

endpackage

// File: rtl/rx_len_acc.sv
// Per-frame byte length and qword accumulator; flags malformed byte-enable
// masks and frames that would exceed MAX_FRM_QW.
module rx_len_acc
    import mac_rx_pkg::*;
#(
    parameter int unsigned MAX_FRM_QW = 190
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        add,
    input  logic [7:0]  dv,
    output logic [15:0] len,
    output logic        room_c,
    output logic        malformed_c
);

    localparam int unsigned QW_W = $clog2(MAX_FRM_QW + 1);

    logic [15:0]     len_q, len_d;
    logic [QW_W-1:0] qw_q, qw_d;
    logic            part_q, part_d;

    always_comb begin
        len_d  = len_q;
        qw_d   = qw_q;
        part_d = part_q;
        if (start) begin
            len_d  = 16'(dv2bytes(dv));
            qw_d   = QW_W'(1);
            part_d = (dv != 8'hFF);
        end else if (add) begin
            len_d  = len_q + 16'(dv2bytes(dv));
            qw_d   = qw_q + QW_W'(1);
            part_d = (dv != 8'hFF);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q  <= 16'd0;
            qw_q   <= '0;
            part_q <= 1'b0;
        end else begin
            len_q  <= len_d;
            qw_q   <= qw_d;
            part_q <= part_d;
        end
    end

    // A beat after a partial beat means the partial one was not the last.
    assign malformed_c = !dv_is_contig(dv) || part_q;
    assign room_c      = (qw_q < QW_W'(MAX_FRM_QW));
    assign len         = len_q;

endmodule

// File: rtl/mac2ibuff.sv
// MAC rx frames -> circular ibuff records ({header, data...}); only whole good
// frames that fit are published through committed_prod.
module mac2ibuff
    import mac_rx_pkg::*;
#(
    parameter int unsigned BW         = 9,
    parameter int unsigned MAX_FRM_QW = 190
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [63:0]   rx_data,
    input  logic [7:0]    rx_data_valid,
    input  logic          rx_good_frame,
    input  logic          rx_bad_frame,
    output logic          wr_en,
    output logic [BW-1:0] wr_addr,
    output logic [63:0]   wr_data,
    output logic [BW:0]   committed_prod,
    input  logic [BW:0]   committed_cons,
    output logic [31:0]   rx_frm_cnt,
    output logic [31:0]   rx_drop_cnt
);

    localparam int unsigned PW = BW + 1;

    rx_state_e       state_q, state_d;
    logic [PW-1:0]   base_q, base_d;
    logic [PW-1:0]   wip_q, wip_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic            wr_en_q, wr_en_d;
    logic [BW-1:0]   wr_addr_q, wr_addr_d;
    logic [63:0]     wr_data_q, wr_data_d;
    logic [31:0]     frm_cnt_q, frm_cnt_d;
    logic [31:0]     drop_cnt_q, drop_cnt_d;

    logic [PW-1:0]   free_c;
    logic            beat_c;
    logic            acc_start_c;
    logic            acc_add_c;
    logic [15:0]     len;
    logic            room_c;
    logic            malformed_c;

    assign beat_c = (rx_data_valid != 8'd0);
    assign free_c = PW'(2 ** BW) - (wip_q - committed_cons);

    rx_len_acc #(
        .MAX_FRM_QW (MAX_FRM_QW)
    ) u_len_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (acc_start_c),
        .add         (acc_add_c),
        .dv          (rx_data_valid),
        .len         (len),
        .room_c      (room_c),
        .malformed_c (malformed_c)
    );

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        wip_d       = wip_q;
        prod_d      = prod_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frm_cnt_d   = frm_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        acc_start_c = 1'b0;
        acc_add_c   = 1'b0;

        unique case (state_q)
            ST_SYNC: begin
                if (!beat_c) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (beat_c) begin
                    base_d = wip_q;
                    if (free_c >= PW'(2) && dv_is_contig(rx_data_valid)) begin
                        wr_en_d     = 1'b1;
                        wr_addr_d   = BW'(wip_q + PW'(1));
                        wr_data_d   = rx_data;
                        wip_d       = wip_q + PW'(2);
                        acc_start_c = 1'b1;
                        state_d     = ST_RCV;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_RCV: begin
                if (rx_bad_frame) begin
                    wip_d      = base_q;
                    drop_cnt_d = drop_cnt_q + 32'd1;
                    state_d    = ST_IDLE;
                end else if (rx_good_frame) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = BW'(base_q);
                    wr_data_d = 64'd0;
                    wr_data_d[HDR_LEN_MSB:HDR_LEN_LSB] = len;
                    prod_d    = wip_q;
                    frm_cnt_d = frm_cnt_q + 32'd1;
                    state_d   = ST_IDLE;
                end else if (beat_c) begin
                    if (free_c >= PW'(1) && room_c && !malformed_c) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = BW'(wip_q);
                        wr_data_d = rx_data;
                        wip_d     = wip_q + PW'(1);
                        acc_add_c = 1'b1;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (rx_good_frame || rx_bad_frame) begin
                    wip_d      = base_q;
                    drop_cnt_d = drop_cnt_q + 32'd1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_SYNC;
            base_q     <= '0;
            wip_q      <= '0;
            prod_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 64'd0;
            frm_cnt_q  <= 32'd0;
            drop_cnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            wip_q      <= wip_d;
            prod_q     <= prod_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            frm_cnt_q  <= frm_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign wr_en          = wr_en_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign committed_prod = prod_q;
    assign rx_frm_cnt     = frm_cnt_q;
    assign rx_drop_cnt    = drop_cnt_q;

endmodule
